// File: rtl/divisor_sequencial_8bits_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package divisor_sequencial_8bits_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIM  = 2'b10
  } state_e;

  localparam logic [WIDTH-1:0] DIV_ZERO_QUOC = 8'hFF;
  localparam logic [2:0]       ITER_LAST     = 3'd7;

endpackage

// File: rtl/divisor_sequencial_8bits_if.sv
// start/busy/done handshake plus operand and result buses of the divider.
interface divisor_sequencial_8bits_if;
  import divisor_sequencial_8bits_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividendo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quociente;
  logic [WIDTH-1:0] resto;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, dividendo, divisor,
    input  quociente, resto, busy, done, div_zero
  );

  modport slave (
    input  start, dividendo, divisor,
    output quociente, resto, busy, done, div_zero
  );

endinterface

// File: rtl/divisor_sequencial_8bits_subtrator.sv
// 8-bit ripple-borrow subtractor: S = A - B - Bin, Bout set on underflow.
module divisor_sequencial_8bits_subtrator
  import divisor_sequencial_8bits_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] S,
  output logic             Bout
);

  logic [WIDTH:0] borrow;

  assign borrow[0] = Bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign S[i]          = A[i] ^ B[i] ^ borrow[i];
    assign borrow[i + 1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow[i]);
  end

  assign Bout = borrow[WIDTH];

endmodule

// File: rtl/divisor_sequencial_8bits.sv
// Sequential unsigned 8/8 restoring divider, one quotient bit per clock,
// with a start/busy/done handshake and a divide-by-zero flag.
module divisor_sequencial_8bits
  import divisor_sequencial_8bits_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  divisor_sequencial_8bits_if.slave   bus
);

  state_e           state;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] div_b;

  logic             msb_out;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             accept;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Trial step: shift {R,Q} left; the bit leaving R makes the partial
  // remainder >= 256 > divisor, so the subtraction is accepted regardless of Bout.
  assign {msb_out, r_shift} = {r_reg, q_reg[WIDTH-1]};

  divisor_sequencial_8bits_subtrator u_sub (
    .A    (r_shift),
    .B    (div_b),
    .Bin  (1'b0),
    .S    (diff),
    .Bout (bout)
  );

  assign accept = msb_out | ~bout;
  assign r_next = accept ? diff : r_shift;
  assign q_next = {q_reg[WIDTH-2:0], accept};

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      r_reg         <= '0;
      q_reg         <= '0;
      div_b         <= '0;
      bus.quociente <= '0;
      bus.resto     <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              bus.quociente <= DIV_ZERO_QUOC;
              bus.resto     <= bus.dividendo;
              bus.div_zero  <= 1'b1;
              bus.done      <= 1'b1;
              state         <= FIM;
            end else begin
              div_b         <= bus.divisor;
              r_reg         <= '0;
              q_reg         <= bus.dividendo;
              cnt           <= '0;
              bus.busy      <= 1'b1;
              bus.div_zero  <= 1'b0;
              state         <= CALC;
            end
          end
        end

        CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + 3'd1;
          if (cnt == ITER_LAST) begin
            bus.quociente <= q_next;
            bus.resto     <= r_next;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= FIM;
          end
        end

        FIM: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_sequencial_8bits.sv
// Self-checking bench: a cycle-level behavioural model using / and % is
// compared against the divider every cycle, plus directed literal checks.
module tb_divisor_sequencial_8bits;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divisor_sequencial_8bits_if bus ();

  divisor_sequencial_8bits dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: results from plain division, timing as a countdown.
  logic [7:0] m_q = '0, m_r = '0, pend_q, pend_r;
  logic       m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  bit         m_run = 1'b0, m_fim = 1'b0;
  int         m_left = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q = '0; m_r = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_run = 1'b0; m_fim = 1'b0; m_left = 0;
    end else if (m_fim) begin
      m_done = 1'b0;
      m_fim  = 1'b0;
    end else if (m_run) begin
      m_left--;
      if (m_left == 0) begin
        m_run = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_fim = 1'b1;
        m_q = pend_q; m_r = pend_r;
      end
    end else if (bus.start) begin
      if (bus.divisor == 8'd0) begin
        m_q = 8'hFF; m_r = bus.dividendo; m_dz = 1'b1; m_done = 1'b1; m_fim = 1'b1;
      end else begin
        pend_q = bus.dividendo / bus.divisor;
        pend_r = bus.dividendo % bus.divisor;
        m_dz = 1'b0; m_busy = 1'b1; m_run = 1'b1; m_left = 8;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model quociente", bus.quociente, m_q);
      check("model resto",     bus.resto,     m_r);
      check("model busy",      bus.busy,      m_busy);
      check("model done",      bus.done,      m_done);
      check("model div_zero",  bus.div_zero,  m_dz);
    end
  end

  // One division with optional ignored start pulses at the given cycle counts.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         input int exp_q, input int exp_r, input int exp_dz,
                         input int exp_cyc, input int exp_busy,
                         input int pulse1 = -1, input int pulse2 = -1);
    int cyc = 0;
    int busy_cnt = 0;
    bus.start     = 1'b1;
    bus.dividendo = a;
    bus.divisor   = b;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (bus.busy) busy_cnt++;
      if (cyc == pulse1 || cyc == pulse2) begin
        bus.start = 1'b1; bus.dividendo = 8'd9; bus.divisor = 8'd3;
      end else begin
        bus.start = 1'b0; bus.dividendo = 8'($urandom); bus.divisor = 8'($urandom);
      end
    end while (!bus.done && cyc < 20);
    check($sformatf("%0d/%0d done cycle", a, b), cyc, exp_cyc);
    check($sformatf("%0d/%0d busy cycles", a, b), busy_cnt, exp_busy);
    check($sformatf("%0d/%0d quociente", a, b), bus.quociente, exp_q);
    check($sformatf("%0d/%0d resto", a, b), bus.resto, exp_r);
    check($sformatf("%0d/%0d div_zero", a, b), bus.div_zero, exp_dz);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%0d/%0d done pulse", a, b), bus.done, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.dividendo = '0; bus.divisor = '0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    check("reset quociente", bus.quociente, 0);
    check("reset resto",     bus.resto,     0);
    check("reset busy",      bus.busy,      0);
    check("reset done",      bus.done,      0);
    check("reset div_zero",  bus.div_zero,  0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Literal results: done after edge N+8 means 9 sampled cycles.
    run_div(8'd100, 8'd7,   14,  2,  0, 9, 8);
    run_div(8'd200, 8'd150, 1,   50, 0, 9, 8);
    run_div(8'd255, 8'd1,   255, 0,  0, 9, 8);
    run_div(8'd0,   8'd5,   0,   0,  0, 9, 8);
    run_div(8'd5,   8'd200, 0,   5,  0, 9, 8);
    run_div(8'd37,  8'd0,   255, 37, 1, 1, 0);
    run_div(8'd81,  8'd9,   9,   0,  0, 9, 8);
    run_div(8'd100, 8'd7,   14,  2,  0, 9, 8, 2, 5);

    // Reset in the middle of a division.
    bus.start = 1'b1; bus.dividendo = 8'd100; bus.divisor = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid busy before reset", bus.busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid reset quociente", bus.quociente, 0);
    check("mid reset resto",     bus.resto,     0);
    check("mid reset busy",      bus.busy,      0);
    check("mid reset done",      bus.done,      0);
    check("mid reset div_zero",  bus.div_zero,  0);
    rst_n = 1'b1;
    run_div(8'd81, 8'd9, 9, 0, 0, 9, 8);

    // Random traffic: starts at any time, occasional zero divisor and reset.
    for (int i = 0; i < 3000; i++) begin
      bus.start     = ($urandom_range(0, 2) == 0);
      bus.dividendo = 8'($urandom);
      bus.divisor   = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      rst_n         = ($urandom_range(0, 399) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
